// File: rtl/seq_div_module.sv
// seq_div_module: multi-cycle restoring divider, signed/unsigned, with quotient, remainder and exception
module seq_div_module #(
  parameter int WIDTH = 32,
  parameter int DIV_WIDTH = 16,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [DIV_WIDTH-1:0] data_operandB,
  input  logic                 ctrl_DIV,
  input  logic                 ctrl_signed,
  output logic [WIDTH-1:0]     data_result,
  output logic [WIDTH-1:0]     data_remainder,
  output logic                 data_exception,
  output logic                 data_inputRDY,
  output logic                 data_resultRDY
);
  localparam int ITER = WIDTH / STEPS_PER_CYCLE;
  localparam int RW = DIV_WIDTH + 1;
  localparam int CW = $clog2(ITER + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] aq, aq_n, a_lat, a_mag, rem_w;
  logic [RW-1:0] rem, rem_n, dvs, b_ext, b_mag, sh;
  logic [RW:0] df;
  logic sgn_q, sgn_r, ovf, dz, accept;
  assign data_inputRDY = state == IDLE || state == DONE;
  assign data_resultRDY = state == DONE;
  assign accept = ctrl_DIV && data_inputRDY;
  assign a_mag = ctrl_signed && data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  // one extra bit so the most negative divisor keeps its positive magnitude
  assign b_ext = {ctrl_signed & data_operandB[DIV_WIDTH-1], data_operandB};
  assign b_mag = b_ext[RW-1] ? -b_ext : b_ext;
  assign rem_w = WIDTH'(rem);
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // divide-by-zero skips RUN but still passes through FIX to register its results
  always_comb
    nxt = accept ? (data_operandB == '0 ? FIX : RUN)
        : state == RUN ? (cnt == CW'(ITER - 1) ? FIX : RUN)
        : state == FIX ? DONE : IDLE;
  // aq shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    rem_n = rem;
    aq_n = aq;
    sh = '0;
    df = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      sh = {rem_n[RW-2:0], aq_n[WIDTH-1]};
      df = {1'b0, sh} - {1'b0, dvs};
      aq_n = {aq_n[WIDTH-2:0], ~df[RW]};
      rem_n = df[RW] ? sh : df[RW-1:0];
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt <= '0;
      aq <= '0;
      a_lat <= '0;
      rem <= '0;
      dvs <= '0;
      sgn_q <= 1'b0;
      sgn_r <= 1'b0;
      ovf <= 1'b0;
      dz <= 1'b0;
      data_result <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      aq <= a_mag;
      a_lat <= data_operandA;
      rem <= '0;
      dvs <= b_mag;
      sgn_q <= ctrl_signed & (data_operandA[WIDTH-1] ^ data_operandB[DIV_WIDTH-1]);
      sgn_r <= ctrl_signed & data_operandA[WIDTH-1];
      ovf <= ctrl_signed && data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB;
      dz <= data_operandB == '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      aq <= aq_n;
      rem <= rem_n;
    end else if (state == FIX) begin
      data_result <= dz ? '0 : sgn_q ? -aq : aq;
      data_remainder <= dz ? a_lat : sgn_r ? -rem_w : rem_w;
      data_exception <= dz | ovf;
    end
endmodule
